// File: rtl/instruction_buffer_pkg.sv
// rtl/instruction_buffer_pkg.sv - sizes, packet layout and packet type for the fetch-to-decode buffer
package instruction_buffer_pkg;

   localparam int SIZE_INSTRUCTION = 64;
   localparam int SIZE_PC          = 32;
   localparam int SIZE_CTI_LOG     = 4;
   localparam int PKT_W            = SIZE_INSTRUCTION + 2*SIZE_PC + SIZE_CTI_LOG + 1;

   localparam int DEPTH          = 16;
   localparam int FETCH_WIDTH    = 4;
   localparam int DISPATCH_WIDTH = 4;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int NWR_W = $clog2(FETCH_WIDTH + 1);

   // Field LSB offsets inside a packet, prediction bit at the bottom
   localparam int PRED_LSB   = 0;
   localparam int CTIQ_LSB   = PRED_LSB + 1;
   localparam int TARGET_LSB = CTIQ_LSB + SIZE_CTI_LOG;
   localparam int PC_LSB     = TARGET_LSB + SIZE_PC;
   localparam int INST_LSB   = PC_LSB + SIZE_PC;

   typedef struct packed {
      logic [SIZE_INSTRUCTION-1:0] inst;
      logic [SIZE_PC-1:0]          pc;
      logic [SIZE_PC-1:0]          target_addr;
      logic [SIZE_CTI_LOG-1:0]     ctiq_tag;
      logic                        prediction;
   } fetch_pkt_t;

endpackage

// File: rtl/instruction_buffer_if.sv
// rtl/instruction_buffer_if.sv - fetch, decode and flush signals of the instruction buffer
interface instruction_buffer_if;
   import instruction_buffer_pkg::*;

   logic                            flush_i;
   logic                            fs2Ready_i;
   logic [FETCH_WIDTH-1:0]          instValid_i;
   logic [FETCH_WIDTH*PKT_W-1:0]    instPacket_i;
   logic                            decodeReady_i;
   logic                            instBufferFull_o;
   logic                            decodeValid_o;
   logic [DISPATCH_WIDTH*PKT_W-1:0] decodePacket_o;
   logic [OCC_W-1:0]                occupancy_o;

   modport master (
      output flush_i, fs2Ready_i, instValid_i, instPacket_i, decodeReady_i,
      input  instBufferFull_o, decodeValid_o, decodePacket_o, occupancy_o
   );

   modport slave (
      input  flush_i, fs2Ready_i, instValid_i, instPacket_i, decodeReady_i,
      output instBufferFull_o, decodeValid_o, decodePacket_o, occupancy_o
   );

endinterface

// File: rtl/instruction_buffer_compactor.sv
// rtl/instruction_buffer_compactor.sv - packs valid fetch lanes into consecutive buffer entries from tail
module instruction_buffer_compactor
   import instruction_buffer_pkg::*;
(
   input  logic                         wr,
   input  logic [PTR_W-1:0]             tail,
   input  logic [FETCH_WIDTH-1:0]       valid,
   input  logic [FETCH_WIDTH*PKT_W-1:0] pkt,
   output logic [DEPTH-1:0]             we,
   output logic [DEPTH*PKT_W-1:0]       wdata,
   output logic [NWR_W-1:0]             n_wr
);

   logic [PTR_W-1:0] offs [FETCH_WIDTH];
   logic [PTR_W-1:0] run;
   logic [PTR_W-1:0] slot;

   always_comb begin
      we    = '0;
      wdata = '0;
      run   = '0;
      slot  = '0;
      // Exclusive prefix sum: lane k lands after every valid lane below it
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         offs[k] = run;
         run     = run + PTR_W'(valid[k]);
      end
      n_wr = run[NWR_W-1:0];
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         if (wr && valid[k]) begin
            slot                       = tail + offs[k];
            we[slot]                   = 1'b1;
            wdata[slot*PKT_W +: PKT_W] = pkt[k*PKT_W +: PKT_W];
         end
      end
   end

endmodule

// File: rtl/instruction_buffer.sv
// rtl/instruction_buffer.sv - fetch-to-decode FIFO: multi-lane compacted writes, fixed-size bundle reads
module instruction_buffer
   import instruction_buffer_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   instruction_buffer_if.slave ib
);

   logic [PKT_W-1:0]           mem [DEPTH];
   logic [PTR_W-1:0]           head, tail;
   logic [CNT_W-1:0]           count, count_next;
   logic                       full, dvalid, wr, rd;
   logic [DEPTH-1:0]           we;
   logic [DEPTH*PKT_W-1:0]     wdata;
   logic [NWR_W-1:0]           n_wr;
   logic [DISPATCH_WIDTH*PKT_W-1:0] rdata;

   // Full ignores a same-cycle read so fetch never depends on decode timing
   assign full   = (CNT_W'(DEPTH) - count) < CNT_W'(FETCH_WIDTH);
   assign dvalid = (count >= CNT_W'(DISPATCH_WIDTH)) & ~ib.flush_i;
   assign wr     = ib.fs2Ready_i & ~full & ~ib.flush_i;
   assign rd     = dvalid & ib.decodeReady_i;

   instruction_buffer_compactor u_compactor (
      .wr    (wr),
      .tail  (tail),
      .valid (ib.instValid_i),
      .pkt   (ib.instPacket_i),
      .we    (we),
      .wdata (wdata),
      .n_wr  (n_wr)
   );

   always_comb begin
      count_next = count + (wr ? CNT_W'(n_wr) : '0) - (rd ? CNT_W'(DISPATCH_WIDTH) : '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (ib.flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (rd) head <= head + PTR_W'(DISPATCH_WIDTH);
         if (wr) tail <= tail + PTR_W'(n_wr);
         count <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      for (int e = 0; e < DEPTH; e++) begin
         if (we[e]) mem[e] <= wdata[e*PKT_W +: PKT_W];
      end
   end

   always_comb begin
      rdata = '0;
      for (int j = 0; j < DISPATCH_WIDTH; j++) begin
         rdata[j*PKT_W +: PKT_W] = mem[head + PTR_W'(j)];
      end
   end

   assign ib.instBufferFull_o = full;
   assign ib.decodeValid_o    = dvalid;
   assign ib.decodePacket_o   = rdata;
   assign ib.occupancy_o      = OCC_W'(count);

endmodule

// File: tb/tb_instruction_buffer.sv
// tb/tb_instruction_buffer.sv - directed self-checking bench for instruction_buffer
module tb_instruction_buffer;
   import instruction_buffer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   instruction_buffer_if ib();

   instruction_buffer dut (
      .clk   (clk),
      .reset (reset),
      .ib    (ib)
   );

   function automatic logic [PKT_W-1:0] mk(input logic [7:0] t);
      fetch_pkt_t p;
      p.inst        = {8{t}};
      p.pc          = {24'h0, t};
      p.target_addr = {t, 24'hABCDEF};
      p.ctiq_tag    = t[3:0];
      p.prediction  = t[0];
      return p;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rdy, input logic [3:0] v,
                        input logic [7:0] t0, input logic [7:0] t1,
                        input logic [7:0] t2, input logic [7:0] t3, input logic dr);
      ib.fs2Ready_i    = rdy;
      ib.instValid_i   = v;
      ib.instPacket_i  = {mk(t3), mk(t2), mk(t1), mk(t0)};
      ib.decodeReady_i = dr;
   endtask

   task automatic do_flush;
      drive(1'b0, 4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0);
      ib.flush_i = 1'b1;
      tick();
      ib.flush_i = 1'b0;
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1 && ib.occupancy_o > 5'(DEPTH)) begin
         $display("FAIL occupancy_bound: got %0d, required <= %0d", ib.occupancy_o, DEPTH);
         n_fail++;
      end
   end

   task automatic test_reset;
      reset = 1'b0;
      ib.flush_i = 1'b0;
      drive(1'b0, 4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0);
      #12;
      n_checks++;
      if (ib.occupancy_o !== 5'd0) begin
         $display("FAIL reset_occ: got %0d, required 0", ib.occupancy_o); n_fail++;
      end
      n_checks++;
      if (ib.decodeValid_o !== 1'b0) begin
         $display("FAIL reset_dvalid: got %b, required 0", ib.decodeValid_o); n_fail++;
      end
      n_checks++;
      if (ib.instBufferFull_o !== 1'b0) begin
         $display("FAIL reset_full: got %b, required 0", ib.instBufferFull_o); n_fail++;
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_fill;
      logic [7:0] b0;
      for (int b = 0; b < 4; b++) begin
         b0 = 8'(8'h10 + 4*b);
         drive(1'b1, 4'b1111, b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3, 1'b0);
         tick();
         n_checks++;
         if (ib.occupancy_o !== 5'(4*(b+1))) begin
            $display("FAIL fill_occ[%0d]: got %0d, required %0d", b, ib.occupancy_o, 4*(b+1)); n_fail++;
         end
         n_checks++;
         if (ib.instBufferFull_o !== (b == 3)) begin
            $display("FAIL fill_full[%0d]: got %b, required %b", b, ib.instBufferFull_o, b == 3); n_fail++;
         end
      end
      drive(1'b1, 4'b1111, 8'h20, 8'h21, 8'h22, 8'h23, 1'b0);
      tick();
      n_checks++;
      if (ib.occupancy_o !== 5'd16) begin
         $display("FAIL fill_ignored_occ: got %0d, required 16", ib.occupancy_o); n_fail++;
      end
      for (int b = 0; b < 4; b++) begin
         drive(1'b0, 4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b1);
         n_checks++;
         if (ib.decodeValid_o !== 1'b1) begin
            $display("FAIL drain_dvalid[%0d]: got %b, required 1", b, ib.decodeValid_o); n_fail++;
         end
         for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (ib.decodePacket_o[j*PKT_W +: PKT_W] !== mk(8'(8'h10 + 4*b + j))) begin
               $display("FAIL drain_pkt[%0d][%0d]: got %h, required %h", b, j,
                        ib.decodePacket_o[j*PKT_W +: PKT_W], mk(8'(8'h10 + 4*b + j))); n_fail++;
            end
         end
         tick();
      end
      n_checks++;
      if (ib.occupancy_o !== 5'd0 || ib.decodeValid_o !== 1'b0 || ib.instBufferFull_o !== 1'b0) begin
         $display("FAIL drain_empty: got occ=%0d dv=%b full=%b, required 0/0/0",
                  ib.occupancy_o, ib.decodeValid_o, ib.instBufferFull_o); n_fail++;
      end
   endtask

   task automatic test_partial_lanes;
      logic [7:0] exp [4];
      exp = '{8'hA0, 8'hB0, 8'hB1, 8'hB2};
      do_flush();
      drive(1'b1, 4'b1000, 8'h0, 8'h0, 8'h0, 8'hA0, 1'b1);
      tick();
      drive(1'b1, 4'b1110, 8'h0, 8'hB0, 8'hB1, 8'hB2, 1'b1);
      n_checks++;
      if (ib.decodeValid_o !== 1'b0) begin
         $display("FAIL partial_no_bypass: got %b, required 0", ib.decodeValid_o); n_fail++;
      end
      tick();
      drive(1'b1, 4'b1100, 8'h0, 8'h0, 8'hC0, 8'hC1, 1'b1);
      n_checks++;
      if (ib.decodeValid_o !== 1'b1) begin
         $display("FAIL partial_dvalid: got %b, required 1", ib.decodeValid_o); n_fail++;
      end
      for (int j = 0; j < 4; j++) begin
         n_checks++;
         if (ib.decodePacket_o[j*PKT_W +: PKT_W] !== mk(exp[j])) begin
            $display("FAIL partial_pkt[%0d]: got %h, required %h", j,
                     ib.decodePacket_o[j*PKT_W +: PKT_W], mk(exp[j])); n_fail++;
         end
      end
      tick();
      drive(1'b0, 4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b1);
      n_checks++;
      if (ib.occupancy_o !== 5'd2 || ib.decodeValid_o !== 1'b0) begin
         $display("FAIL partial_remain: got occ=%0d dv=%b, required 2/0", ib.occupancy_o, ib.decodeValid_o); n_fail++;
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] b0;
      do_flush();
      for (int i = 1; i <= 6; i++) begin
         b0 = 8'(8'h30 + 4*(i-1));
         drive(1'b1, 4'b1111, b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3, i >= 3);
         if (i >= 3) begin
            n_checks++;
            if (ib.occupancy_o !== 5'd8) begin
               $display("FAIL b2b_occ[%0d]: got %0d, required 8", i, ib.occupancy_o); n_fail++;
            end
            for (int j = 0; j < 4; j++) begin
               n_checks++;
               if (ib.decodePacket_o[j*PKT_W +: PKT_W] !== mk(8'(8'h30 + 4*(i-3) + j))) begin
                  $display("FAIL b2b_pkt[%0d][%0d]: got %h, required %h", i, j,
                           ib.decodePacket_o[j*PKT_W +: PKT_W], mk(8'(8'h30 + 4*(i-3) + j))); n_fail++;
               end
            end
         end
         tick();
      end
      drive(1'b0, 4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0);
      n_checks++;
      if (ib.occupancy_o !== 5'd8) begin
         $display("FAIL b2b_final_occ: got %0d, required 8", ib.occupancy_o); n_fail++;
      end
      for (int j = 0; j < 4; j++) begin
         n_checks++;
         if (ib.decodePacket_o[j*PKT_W +: PKT_W] !== mk(8'(8'h40 + j))) begin
            $display("FAIL b2b_wrap_pkt[%0d]: got %h, required %h", j,
                     ib.decodePacket_o[j*PKT_W +: PKT_W], mk(8'(8'h40 + j))); n_fail++;
         end
      end
   endtask

   task automatic test_tail_wrap;
      logic [7:0] exp1 [4];
      logic [7:0] exp2 [4];
      exp1 = '{8'h5C, 8'h5D, 8'h60, 8'h61};
      exp2 = '{8'h62, 8'h63, 8'h64, 8'h65};
      do_flush();
      drive(1'b1, 4'b1111, 8'h50, 8'h51, 8'h52, 8'h53, 1'b0); tick();
      drive(1'b1, 4'b1111, 8'h54, 8'h55, 8'h56, 8'h57, 1'b0); tick();
      drive(1'b1, 4'b1111, 8'h58, 8'h59, 8'h5A, 8'h5B, 1'b0); tick();
      drive(1'b1, 4'b1100, 8'h0, 8'h0, 8'h5C, 8'h5D, 1'b0); tick();
      for (int b = 0; b < 3; b++) begin
         drive(1'b0, 4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b1);
         tick();
      end
      drive(1'b1, 4'b1111, 8'h60, 8'h61, 8'h62, 8'h63, 1'b0);
      tick();
      n_checks++;
      if (ib.occupancy_o !== 5'd6) begin
         $display("FAIL wrap_occ: got %0d, required 6", ib.occupancy_o); n_fail++;
      end
      for (int j = 0; j < 4; j++) begin
         n_checks++;
         if (ib.decodePacket_o[j*PKT_W +: PKT_W] !== mk(exp1[j])) begin
            $display("FAIL wrap_pkt1[%0d]: got %h, required %h", j,
                     ib.decodePacket_o[j*PKT_W +: PKT_W], mk(exp1[j])); n_fail++;
         end
      end
      drive(1'b1, 4'b0011, 8'h64, 8'h65, 8'h0, 8'h0, 1'b1);
      tick();
      drive(1'b0, 4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0);
      n_checks++;
      if (ib.occupancy_o !== 5'd4) begin
         $display("FAIL wrap_occ2: got %0d, required 4", ib.occupancy_o); n_fail++;
      end
      for (int j = 0; j < 4; j++) begin
         n_checks++;
         if (ib.decodePacket_o[j*PKT_W +: PKT_W] !== mk(exp2[j])) begin
            $display("FAIL wrap_pkt2[%0d]: got %h, required %h", j,
                     ib.decodePacket_o[j*PKT_W +: PKT_W], mk(exp2[j])); n_fail++;
         end
      end
   endtask

   task automatic test_flush;
      do_flush();
      drive(1'b1, 4'b1111, 8'h80, 8'h81, 8'h82, 8'h83, 1'b0); tick();
      drive(1'b1, 4'b1111, 8'h84, 8'h85, 8'h86, 8'h87, 1'b0); tick();
      drive(1'b1, 4'b1000, 8'h0, 8'h0, 8'h0, 8'h88, 1'b0); tick();
      n_checks++;
      if (ib.occupancy_o !== 5'd9) begin
         $display("FAIL flush_setup_occ: got %0d, required 9", ib.occupancy_o); n_fail++;
      end
      drive(1'b1, 4'b1111, 8'h90, 8'h91, 8'h92, 8'h93, 1'b1);
      ib.flush_i = 1'b1;
      #1;
      n_checks++;
      if (ib.decodeValid_o !== 1'b0) begin
         $display("FAIL flush_masks_dvalid: got %b, required 0", ib.decodeValid_o); n_fail++;
      end
      tick();
      ib.flush_i = 1'b0;
      drive(1'b0, 4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0);
      #1;
      n_checks++;
      if (ib.occupancy_o !== 5'd0 || ib.decodeValid_o !== 1'b0 || ib.instBufferFull_o !== 1'b0) begin
         $display("FAIL flush_result: got occ=%0d dv=%b full=%b, required 0/0/0",
                  ib.occupancy_o, ib.decodeValid_o, ib.instBufferFull_o); n_fail++;
      end
   endtask

   task automatic test_async_reset;
      do_flush();
      drive(1'b1, 4'b1111, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 1'b0); tick();
      drive(1'b1, 4'b1110, 8'h0, 8'hE4, 8'hE5, 8'hE6, 1'b0); tick();
      drive(1'b1, 4'b1111, 8'hE7, 8'hE8, 8'hE9, 8'hEA, 1'b0);
      n_checks++;
      if (ib.occupancy_o !== 5'd7 || ib.decodeValid_o !== 1'b1) begin
         $display("FAIL areset_setup: got occ=%0d dv=%b, required 7/1", ib.occupancy_o, ib.decodeValid_o); n_fail++;
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (ib.occupancy_o !== 5'd0 || ib.decodeValid_o !== 1'b0 || ib.instBufferFull_o !== 1'b0) begin
         $display("FAIL areset_immediate: got occ=%0d dv=%b full=%b, required 0/0/0",
                  ib.occupancy_o, ib.decodeValid_o, ib.instBufferFull_o); n_fail++;
      end
      drive(1'b0, 4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      n_checks++;
      if (ib.occupancy_o !== 5'd0) begin
         $display("FAIL areset_after_release: got %0d, required 0", ib.occupancy_o); n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_partial_lanes();
      test_back_to_back();
      test_tail_wrap();
      test_flush();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
